// File: rtl/history_reader.sv
// Retains the last DEPTH written values in a circular buffer and answers
// indexed "k writes ago" lookups with a registered, one-cycle response.
module history_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int SAFE  = 0,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] in,
    input  logic             flush,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_hit,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] fill
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] wp_reg;
    logic [IDX_W-1:0] wp_next;
    logic [CNT_W-1:0] fill_reg;
    logic [CNT_W-1:0] fill_next;
    logic             rd_valid_reg;
    logic             rd_hit_reg;
    logic [WIDTH-1:0] rd_data_reg;

    logic [IDX_W:0]   wp_ext;
    logic [IDX_W:0]   back_dist;
    logic [IDX_W-1:0] rd_addr;
    logic             lookup_hit;
    logic [WIDTH-1:0] miss_data;

    generate
        if (SAFE != 0) begin : g_safe_miss
            assign miss_data = '0;
        end else begin : g_x_miss
            assign miss_data = {WIDTH{1'bx}};
        end
    endgenerate

    assign wp_next = (wp_reg == IDX_W'(DEPTH - 1)) ? '0 : wp_reg + 1'b1;

    // Flush clears first, so a simultaneous write restarts the count at one.
    always_comb begin
        fill_next = flush ? '0 : fill_reg;
        if (write_en && (fill_next != CNT_W'(DEPTH))) begin
            fill_next = fill_next + 1'b1;
        end
    end

    // Entry k back lives at (wp-1-k) mod DEPTH; only meaningful on a hit,
    // where k < fill <= DEPTH keeps the borrow path below DEPTH.
    assign wp_ext     = {1'b0, wp_reg};
    assign back_dist  = {1'b0, rd_idx} + 1'b1;
    assign rd_addr    = (wp_ext >= back_dist) ? IDX_W'(wp_ext - back_dist)
                                              : IDX_W'(wp_ext + (IDX_W + 1)'(DEPTH) - back_dist);
    assign lookup_hit = ((IDX_W + 1)'(rd_idx) < (IDX_W + 1)'(fill_reg));

    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            mem[wp_reg] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_reg       <= '0;
            fill_reg     <= '0;
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            if (write_en) begin
                wp_reg <= wp_next;
            end
            fill_reg     <= fill_next;
            rd_valid_reg <= rd_en;
            rd_hit_reg   <= rd_en && lookup_hit;
            // Non-blocking read sees the array before any same-cycle write.
            if (rd_en) begin
                rd_data_reg <= lookup_hit ? mem[rd_addr] : miss_data;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_hit   = rd_hit_reg;
    assign rd_data  = rd_data_reg;
    assign fill     = fill_reg;

endmodule

// File: tb/tb_history_reader.sv
// Drives a DEPTH=4/SAFE=1 and a DEPTH=3/SAFE=0 history_reader with identical
// stimulus and compares both against a queue-based history model.
module tb_history_reader;

    logic        clk;
    logic        reset;
    logic        write_en;
    logic [31:0] din;
    logic        flush;
    logic        rd_en;
    logic [1:0]  rd_idx;

    logic        rd_valid_a, rd_hit_a;
    logic [31:0] rd_data_a;
    logic [2:0]  fill_a;
    logic        rd_valid_b, rd_hit_b;
    logic [31:0] rd_data_b;
    logic [1:0]  fill_b;

    int tests_run = 0;
    int tests_failed = 0;

    // Newest write at index 0; everything written since the last reset/flush.
    logic [31:0] hist[$];
    logic [31:0] exp_data_a = '0;
    logic [31:0] exp_data_b = '0;
    logic        known_b = 1'b1;

    history_reader #(.WIDTH(32), .DEPTH(4), .SAFE(1)) dut_a (
        .clk(clk), .reset(reset), .write_en(write_en), .in(din), .flush(flush),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_a), .rd_hit(rd_hit_a),
        .rd_data(rd_data_a), .fill(fill_a)
    );

    history_reader #(.WIDTH(32), .DEPTH(3), .SAFE(0)) dut_b (
        .clk(clk), .reset(reset), .write_en(write_en), .in(din), .flush(flush),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid_b), .rd_hit(rd_hit_b),
        .rd_data(rd_data_b), .fill(fill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input logic rst, input logic we, input logic fl,
                        input logic re, input logic [1:0] idx, input logic [31:0] d);
        logic ev, eh_a, eh_b;
        int   fa, fb;
        reset = rst; write_en = we; flush = fl; rd_en = re; rd_idx = idx; din = d;
        fa = min_int(hist.size(), 4);
        fb = min_int(hist.size(), 3);
        ev = 1'b0; eh_a = 1'b0; eh_b = 1'b0;
        if (rst) begin
            exp_data_a = '0; exp_data_b = '0; known_b = 1'b1;
        end else if (re) begin
            ev   = 1'b1;
            eh_a = (int'(idx) < fa);
            eh_b = (int'(idx) < fb);
            exp_data_a = eh_a ? hist[idx] : '0;
            known_b    = eh_b;
            if (eh_b) exp_data_b = hist[idx];
        end
        if (rst) begin
            hist.delete();
        end else begin
            if (fl) hist.delete();
            if (we) hist.push_front(d);
            if (hist.size() > 8) void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        $display("[TB] rst=%0b we=%0b fl=%0b re=%0b idx=%0d in=%h | A v=%0b h=%0b d=%h f=%0d | B v=%0b h=%0b d=%h f=%0d",
                 rst, we, fl, re, idx, d, rd_valid_a, rd_hit_a, rd_data_a, fill_a,
                 rd_valid_b, rd_hit_b, rd_data_b, fill_b);
        check("a_valid", 32'(rd_valid_a), 32'(ev));
        check("a_hit",   32'(rd_hit_a),   32'(eh_a));
        check("a_data",  rd_data_a,       exp_data_a);
        check("a_fill",  32'(fill_a),     32'(min_int(hist.size(), 4)));
        check("b_valid", 32'(rd_valid_b), 32'(ev));
        check("b_hit",   32'(rd_hit_b),   32'(eh_b));
        if (known_b) check("b_data", rd_data_b, exp_data_b);
        check("b_fill",  32'(fill_b),     32'(min_int(hist.size(), 3)));
    endtask

    task automatic wr(input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, d);
    endtask

    task automatic rd(input logic [1:0] idx);
        step(1'b0, 1'b0, 1'b0, 1'b1, idx, 32'h0);
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; flush = 1'b0; rd_en = 1'b0; rd_idx = '0; din = '0;

        // Reset state, then a lookup into empty history.
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        rd(2'd0);

        // Three writes, then back-to-back reads including a miss.
        wr(32'h11); wr(32'h22); wr(32'h33);
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

        // Wrap: seven writes after a flush, DEPTH=3 keeps 7,6,5.
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        for (int i = 1; i <= 7; i++) wr(32'(i));
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        wr(32'h8); rd(2'd2);

        // Same-cycle write and read: read sees the older value.
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'hA);
        wr(32'hB);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'hC);
        rd(2'd0);

        // Full history, then flush together with a write.
        wr(32'h1); wr(32'h2); wr(32'h3); wr(32'h4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h5A);
        rd(2'd0); rd(2'd1);

        // Reset mid-stream drops the pending response.
        wr(32'h77);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0);
        rd(2'd0); rd(2'd1);
        wr(32'h99); rd(2'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
